// File: rtl/snitch_shared_muldiv_arb_pkg.sv
// Shared helpers for the shared MULDIV arbiter slice.
//
// Contents:
//   idx_width(n) : bit width needed to index n entries (at least 1 bit).
//   cnt_width(n) : bit width needed to hold a count 0..n.
package snitch_shared_muldiv_arb_pkg;

   // Width of an index into n entries; a single entry still gets one bit so
   // that the index type never collapses to zero width.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must represent every value from 0 up to n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/snitch_shared_muldiv_arb_fifo.sv
// Ownership queue for the shared MULDIV arbiter.
//
// A plain registered FIFO (no fall-through): the head entry is visible on
// data_o one cycle after it was pushed. Pushes into a full queue and pops
// from an empty queue are ignored.
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the queue)
//   push_i       : write data_i at the tail
//   data_i       : entry to write
//   pop_i        : remove the head entry
//   data_o       : current head entry (valid while empty_o is 0)
//   full_o       : Depth entries stored
//   empty_o      : no entries stored
module snitch_shared_muldiv_arb_fifo
   import snitch_shared_muldiv_arb_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = idx_width(Depth);
   localparam int unsigned CntW = cnt_width(Depth);

   typedef logic [PtrW-1:0] ptr_t;

   logic [Width-1:0] mem_q [Depth];
   ptr_t             wr_ptr_q;
   ptr_t             rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Pointers wrap explicitly so Depth need not be a power of two.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         // Simultaneous push and pop leave the count unchanged.
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (do_pop && !do_push) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/snitch_shared_muldiv_arb.sv
// Round-robin arbiter sharing one multiply/divide unit among NrPorts cores.
//
// Requests from the cores are arbitrated round-robin and forwarded to the
// single unit. The index of every issued request is recorded in an ownership
// queue; since the unit answers strictly in issue order, the queue head
// names the core each response belongs to.
//
// Ports:
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   in_req_valid_i/in_req_ready_o  : per-core request handshake
//   in_req_op_i/id_i/arga_i/argb_i : per-core request payload
//   out_req_valid_o/out_req_ready_i: request handshake to the unit
//   out_req_op_o/id_o/arga_o/argb_o: request payload of the granted core
//   in_rsp_valid_i/in_rsp_ready_o  : response handshake from the unit
//   in_rsp_data_i/id_i/error_i     : response payload from the unit
//   out_rsp_valid_o/out_rsp_ready_i: per-core response handshake
//   out_rsp_data_o/id_o/error_o    : response payload, broadcast to all cores
//   busy_o                         : at least one operation outstanding
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. A source holding valid keeps its payload stable until the transfer;
// ready may depend combinationally on valid, valid never depends on ready.
module snitch_shared_muldiv_arb
   import snitch_shared_muldiv_arb_pkg::*;
#(
   parameter int unsigned NrPorts        = 4,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned IdWidth        = 5
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NrPorts-1:0]                 in_req_valid_i,
   output logic [NrPorts-1:0]                 in_req_ready_o,
   input  logic [NrPorts-1:0][31:0]           in_req_op_i,
   input  logic [NrPorts-1:0][IdWidth-1:0]    in_req_id_i,
   input  logic [NrPorts-1:0][DataWidth-1:0]  in_req_arga_i,
   input  logic [NrPorts-1:0][DataWidth-1:0]  in_req_argb_i,
   output logic                               out_req_valid_o,
   input  logic                               out_req_ready_i,
   output logic [31:0]                        out_req_op_o,
   output logic [IdWidth-1:0]                 out_req_id_o,
   output logic [DataWidth-1:0]               out_req_arga_o,
   output logic [DataWidth-1:0]               out_req_argb_o,
   input  logic                               in_rsp_valid_i,
   output logic                               in_rsp_ready_o,
   input  logic [DataWidth-1:0]               in_rsp_data_i,
   input  logic [IdWidth-1:0]                 in_rsp_id_i,
   input  logic                               in_rsp_error_i,
   output logic [NrPorts-1:0]                 out_rsp_valid_o,
   input  logic [NrPorts-1:0]                 out_rsp_ready_i,
   output logic [DataWidth-1:0]               out_rsp_data_o,
   output logic [IdWidth-1:0]                 out_rsp_id_o,
   output logic                               out_rsp_error_o,
   output logic                               busy_o
);

   localparam int unsigned IdxW = idx_width(NrPorts);

   typedef logic [IdxW-1:0] idx_t;

   idx_t rr_q;
   idx_t lock_idx_q;
   logic lock_q;
   idx_t grant;
   logic grant_valid;
   idx_t own;
   logic full;
   logic empty;
   logic req_hs;
   logic rsp_hs;

   // ---------------------------------------------------------------------
   // Request arbitration
   // ---------------------------------------------------------------------

   // Walking the valid vector starting at rr_q is a leading-one search over
   // the rotated vector: the lowest valid index >= rr_q wins, otherwise the
   // search wraps to the lowest valid index below rr_q.
   always_comb begin : rr_select
      logic        found;
      int unsigned pos;
      found = 1'b0;
      pos   = 0;
      grant = lock_idx_q;
      if (!lock_q) begin
         grant = '0;
         for (int unsigned i = 0; i < NrPorts; i++) begin
            pos = (32'(rr_q) + i) % NrPorts;
            if (!found && in_req_valid_i[pos[IdxW-1:0]]) begin
               grant = pos[IdxW-1:0];
               found = 1'b1;
            end
         end
      end
   end

   assign grant_valid = in_req_valid_i[grant];

   // A full ownership queue blocks issue outright, even when a response pops
   // an entry in the same cycle; this keeps ready free of the response path.
   assign out_req_valid_o = !rst_i && grant_valid && !full;
   assign req_hs          = out_req_valid_o && out_req_ready_i;

   always_comb begin
      in_req_ready_o = '0;
      if (!rst_i && !full) begin
         in_req_ready_o[grant] = out_req_ready_i;
      end
   end

   assign out_req_op_o   = in_req_op_i[grant];
   assign out_req_id_o   = in_req_id_i[grant];
   assign out_req_arga_o = in_req_arga_i[grant];
   assign out_req_argb_o = in_req_argb_i[grant];

   // Once a request is offered and stalled, the grant is frozen so that the
   // payload seen by the unit cannot change before it is accepted. While the
   // queue is full nothing is offered and the lock state is left untouched.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (req_hs) begin
         rr_q   <= (grant == idx_t'(NrPorts - 1)) ? '0 : grant + idx_t'(1);
         lock_q <= 1'b0;
      end else if (out_req_valid_o) begin
         lock_q     <= 1'b1;
         lock_idx_q <= grant;
      end
   end

   // ---------------------------------------------------------------------
   // Ownership tracking
   // ---------------------------------------------------------------------

   snitch_shared_muldiv_arb_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdxW)
   ) i_owner_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (req_hs),
      .data_i  (grant),
      .pop_i   (rsp_hs),
      .data_o  (own),
      .full_o  (full),
      .empty_o (empty)
   );

   assign busy_o = !empty;

   // ---------------------------------------------------------------------
   // Response routing
   // ---------------------------------------------------------------------

   always_comb begin
      out_rsp_valid_o = '0;
      if (!rst_i && !empty) begin
         out_rsp_valid_o[own] = in_rsp_valid_i;
      end
   end

   assign in_rsp_ready_o  = !rst_i && !empty && out_rsp_ready_i[own];
   assign rsp_hs          = in_rsp_valid_i && in_rsp_ready_o;

   assign out_rsp_data_o  = in_rsp_data_i;
   assign out_rsp_id_o    = in_rsp_id_i;
   assign out_rsp_error_o = in_rsp_error_i;

`ifndef SYNTHESIS
   // The unit can only answer operations it was given; a response with no
   // recorded owner means the environment did not drain the unit on reset.
   rsp_without_owner: assert property (
      @(posedge clk_i) disable iff (rst_i) !(in_rsp_valid_i && empty)
   );
`endif

endmodule

// File: tb/tb_snitch_shared_muldiv_arb.sv
// Directed, table-driven bench for snitch_shared_muldiv_arb (4 ports,
// 4 outstanding). Each table row is one clock cycle: inputs are driven just
// after the rising edge, outputs are compared on the falling edge, and the
// next rising edge commits the cycle. State carries over from row to row.
module tb_snitch_shared_muldiv_arb;

   localparam int unsigned NrPorts = 4;
   localparam int unsigned MaxOut  = 4;
   localparam int unsigned DataW   = 32;
   localparam int unsigned IdW     = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [NrPorts-1:0]            in_req_valid;
   logic [NrPorts-1:0]            in_req_ready;
   logic [NrPorts-1:0][31:0]      in_req_op;
   logic [NrPorts-1:0][IdW-1:0]   in_req_id;
   logic [NrPorts-1:0][DataW-1:0] in_req_arga;
   logic [NrPorts-1:0][DataW-1:0] in_req_argb;
   logic                          out_req_valid;
   logic                          out_req_ready;
   logic [31:0]                   out_req_op;
   logic [IdW-1:0]                out_req_id;
   logic [DataW-1:0]              out_req_arga;
   logic [DataW-1:0]              out_req_argb;
   logic                          in_rsp_valid;
   logic                          in_rsp_ready;
   logic [DataW-1:0]              in_rsp_data;
   logic [IdW-1:0]                in_rsp_id;
   logic                          in_rsp_error;
   logic [NrPorts-1:0]            out_rsp_valid;
   logic [NrPorts-1:0]            out_rsp_ready;
   logic [DataW-1:0]              out_rsp_data;
   logic [IdW-1:0]                out_rsp_id;
   logic                          out_rsp_error;
   logic                          busy;

   snitch_shared_muldiv_arb #(
      .NrPorts        (NrPorts),
      .MaxOutstanding (MaxOut),
      .DataWidth      (DataW),
      .IdWidth        (IdW)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .in_req_valid_i  (in_req_valid),
      .in_req_ready_o  (in_req_ready),
      .in_req_op_i     (in_req_op),
      .in_req_id_i     (in_req_id),
      .in_req_arga_i   (in_req_arga),
      .in_req_argb_i   (in_req_argb),
      .out_req_valid_o (out_req_valid),
      .out_req_ready_i (out_req_ready),
      .out_req_op_o    (out_req_op),
      .out_req_id_o    (out_req_id),
      .out_req_arga_o  (out_req_arga),
      .out_req_argb_o  (out_req_argb),
      .in_rsp_valid_i  (in_rsp_valid),
      .in_rsp_ready_o  (in_rsp_ready),
      .in_rsp_data_i   (in_rsp_data),
      .in_rsp_id_i     (in_rsp_id),
      .in_rsp_error_i  (in_rsp_error),
      .out_rsp_valid_o (out_rsp_valid),
      .out_rsp_ready_i (out_rsp_ready),
      .out_rsp_data_o  (out_rsp_data),
      .out_rsp_id_o    (out_rsp_id),
      .out_rsp_error_o (out_rsp_error),
      .busy_o          (busy)
   );

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  req_valid;
      logic        unit_ready;
      logic        rsp_valid;
      logic [31:0] rsp_data;
      logic [3:0]  rsp_ready;
      logic        exp_req_valid;
      logic [1:0]  exp_grant;
      logic [3:0]  exp_req_ready;
      logic [3:0]  exp_rsp_valid;
      logic        exp_rsp_ready;
      logic        exp_busy;
      logic        chk_busy;
   } vec_t;

   vec_t vecs[$];

   int n_vec = 0;
   int n_err = 0;

   function automatic vec_t mk(
      input string name, input logic r, input logic [3:0] rv, input logic ur,
      input logic sv, input logic [31:0] sd, input logic [3:0] sr,
      input logic erv, input logic [1:0] eg, input logic [3:0] err,
      input logic [3:0] esv, input logic esr, input logic eb, input logic cb);
      vec_t v;
      v.name = name; v.rst = r; v.req_valid = rv; v.unit_ready = ur;
      v.rsp_valid = sv; v.rsp_data = sd; v.rsp_ready = sr;
      v.exp_req_valid = erv; v.exp_grant = eg; v.exp_req_ready = err;
      v.exp_rsp_valid = esv; v.exp_rsp_ready = esr; v.exp_busy = eb;
      v.chk_busy = cb;
      return v;
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst           = v.rst;
      in_req_valid  = v.req_valid;
      out_req_ready = v.unit_ready;
      in_rsp_valid  = v.rsp_valid;
      in_rsp_data   = v.rsp_data;
      in_rsp_id     = v.rsp_data[4:0];
      in_rsp_error  = v.rsp_data[0];
      out_rsp_ready = v.rsp_ready;
   endtask

   task automatic compare(input vec_t v);
      logic [31:0] g;
      g = 32'(v.exp_grant);
      check({v.name, ".req_valid"}, 64'(out_req_valid), 64'(v.exp_req_valid));
      check({v.name, ".req_ready"}, 64'(in_req_ready), 64'(v.exp_req_ready));
      if (v.exp_req_valid) begin
         check({v.name, ".req_op"}, 64'(out_req_op), 64'(32'hA000_0000 | g));
         check({v.name, ".req_id"}, 64'(out_req_id), 64'(g + 32'd1));
         check({v.name, ".req_args"}, {out_req_arga, out_req_argb},
               {32'h0000_1000 + g, 32'h0000_2000 + g});
      end
      check({v.name, ".rsp_valid"}, 64'(out_rsp_valid), 64'(v.exp_rsp_valid));
      check({v.name, ".rsp_ready"}, 64'(in_rsp_ready), 64'(v.exp_rsp_ready));
      check({v.name, ".rsp_payload"}, 64'({out_rsp_data, out_rsp_id, out_rsp_error}),
            64'({v.rsp_data, v.rsp_data[4:0], v.rsp_data[0]}));
      if (v.chk_busy) begin
         check({v.name, ".busy"}, 64'(busy), 64'(v.exp_busy));
      end
   endtask

   // ---------------- test ----------------
   initial begin
      for (int c = 0; c < NrPorts; c++) begin
         in_req_op[c]   = 32'hA000_0000 | 32'(c);
         in_req_id[c]   = IdW'(c + 1);
         in_req_arga[c] = 32'h0000_1000 + 32'(c);
         in_req_argb[c] = 32'h0000_2000 + 32'(c);
      end

      //                 name              rst rv       ur    sv    data          sr       erv  g  err      esv      esr  eb  cb
      // reset forces every handshake output low
      vecs.push_back(mk("rst_hold",        1, 4'b1111, 1'b1, 1'b1, 32'h0000_0000, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0, 1));
      // single request from core 2, then its response
      vecs.push_back(mk("single_req",      0, 4'b0100, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 2, 4'b0100, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("single_rsp",      0, 4'b0000, 1'b0, 1'b1, 32'h0000_1234, 4'b1111, 0, 0, 4'b0000, 4'b0100, 1, 1, 1));
      // rr pointer now 3: core 3 wins over core 0
      vecs.push_back(mk("rr_after_2",      0, 4'b1001, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 3, 4'b1000, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("rsp_core3",       0, 4'b0000, 1'b0, 1'b1, 32'h0000_0055, 4'b1111, 0, 0, 4'b0000, 4'b1000, 1, 1, 1));
      // all cores valid, unit always ready: 0,1,2,3 then queue full
      vecs.push_back(mk("all_g0",          0, 4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("all_g1",          0, 4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 1, 1));
      vecs.push_back(mk("all_g2",          0, 4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 2, 4'b0100, 4'b0000, 0, 1, 1));
      vecs.push_back(mk("all_g3_wrap",     0, 4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 3, 4'b1000, 4'b0000, 0, 1, 1));
      vecs.push_back(mk("full_block",      0, 4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 1));
      vecs.push_back(mk("full_pop_block",  0, 4'b1111, 1'b1, 1'b1, 32'h0000_00D0, 4'b1111, 0, 0, 4'b0000, 4'b0001, 1, 1, 1));
      vecs.push_back(mk("full_reissue_g0", 0, 4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 1, 1));
      // drain in issue order 1,2,3,0 with core 3 stalling its response
      vecs.push_back(mk("rsp_c1",          0, 4'b0000, 1'b0, 1'b1, 32'h0000_00D1, 4'b1111, 0, 0, 4'b0000, 4'b0010, 1, 1, 1));
      vecs.push_back(mk("rsp_c2",          0, 4'b0000, 1'b0, 1'b1, 32'h0000_00D2, 4'b1111, 0, 0, 4'b0000, 4'b0100, 1, 1, 1));
      vecs.push_back(mk("rsp_c3_stall0",   0, 4'b0000, 1'b0, 1'b1, 32'h0000_00D3, 4'b0111, 0, 0, 4'b0000, 4'b1000, 0, 1, 1));
      vecs.push_back(mk("rsp_c3_stall1",   0, 4'b0000, 1'b0, 1'b1, 32'h0000_00D3, 4'b0111, 0, 0, 4'b0000, 4'b1000, 0, 1, 1));
      vecs.push_back(mk("rsp_c3_go",       0, 4'b0000, 1'b0, 1'b1, 32'h0000_00D3, 4'b1111, 0, 0, 4'b0000, 4'b1000, 1, 1, 1));
      vecs.push_back(mk("rsp_c0",          0, 4'b0000, 1'b0, 1'b1, 32'h0000_D00D, 4'b1111, 0, 0, 4'b0000, 4'b0001, 1, 1, 1));
      // unit stalls core 1 for 3 cycles while core 0 joins
      vecs.push_back(mk("stall_c1_a",      0, 4'b0010, 1'b0, 1'b0, 32'h0,        4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("stall_c1_b",      0, 4'b0011, 1'b0, 1'b0, 32'h0,        4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("stall_c1_c",      0, 4'b0011, 1'b0, 1'b0, 32'h0,        4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("stall_c1_go",     0, 4'b0011, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("after_stall_c0",  0, 4'b0001, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 1, 1));
      vecs.push_back(mk("rsp_c1_b",        0, 4'b0000, 1'b0, 1'b1, 32'h0000_00E1, 4'b1111, 0, 0, 4'b0000, 4'b0010, 1, 1, 1));
      vecs.push_back(mk("rsp_c0_b",        0, 4'b0000, 1'b0, 1'b1, 32'h0000_00E0, 4'b1111, 0, 0, 4'b0000, 4'b0001, 1, 1, 1));
      // three outstanding (1,2,0), rr left at 1, then reset
      vecs.push_back(mk("pre_rst_g1",      0, 4'b0111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("pre_rst_g2",      0, 4'b0111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 2, 4'b0100, 4'b0000, 0, 1, 1));
      vecs.push_back(mk("pre_rst_g0",      0, 4'b0111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 1, 1));
      vecs.push_back(mk("rst_mid",         1, 4'b1111, 1'b1, 1'b1, 32'h0000_0BAD, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("post_rst_g0",     0, 4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("post_rst_rsp",    0, 4'b0000, 1'b0, 1'b1, 32'h0000_00F0, 4'b1111, 0, 0, 4'b0000, 4'b0001, 1, 1, 1));
      vecs.push_back(mk("idle",            0, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1));

      // initial reset, two edges
      rst           = 1'b1;
      in_req_valid  = '0;
      out_req_ready = 1'b0;
      in_rsp_valid  = 1'b0;
      in_rsp_data   = '0;
      in_rsp_id     = '0;
      in_rsp_error  = 1'b0;
      out_rsp_ready = '0;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         #1;
         drive(vecs[i]);
         @(negedge clk);
         compare(vecs[i]);
         @(posedge clk);
      end

      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/snitch_shared_muldiv_arb.md
# snitch_shared_muldiv_arb

Round-robin arbiter that shares one `SHARED_MULDIV` accelerator unit among `NrPorts` Snitch cores of a cluster. It sits between the per-core accelerator demux outputs for address `SHARED_MULDIV` (=1) and the single shared multiply/divide unit. It tracks which core owns each outstanding operation and routes the in-order responses back to that core.

## Interface
Parameters:
- `NrPorts`, 4, number of requesting cores (≥2).
- `MaxOutstanding`, 4, ownership queue depth (≥1).
- `DataWidth`, 32, operand/result width.
- `IdWidth`, 5, destination-register tag width.

Ports (clock, then reset):
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous and active-high.
- `in_req_valid_i` in [NrPorts]: per-core request valid.
- `in_req_ready_o` out [NrPorts]: per-core request ready.
- `in_req_op_i` in [NrPorts][31:0]: offloaded instruction word.
- `in_req_id_i` in [NrPorts][IdWidth]: rd tag.
- `in_req_arga_i`, `in_req_argb_i` in [NrPorts][DataWidth]: operands.
- `out_req_valid_o` out 1 / `out_req_ready_i` in 1: request to the unit.
- `out_req_op_o` out 32, `out_req_id_o` out IdWidth, `out_req_arga_o`/`out_req_argb_o` out DataWidth: muxed request payload.
- `in_rsp_valid_i` in 1 / `in_rsp_ready_o` out 1: response from the unit.
- `in_rsp_data_i` in DataWidth, `in_rsp_id_i` in IdWidth, `in_rsp_error_i` in 1: response payload.
- `out_rsp_valid_o` out [NrPorts] / `out_rsp_ready_i` in [NrPorts]: per-core response handshake.
- `out_rsp_data_o` out DataWidth, `out_rsp_id_o` out IdWidth, `out_rsp_error_o` out 1: response payload, broadcast to all cores.
- `busy_o` out 1: at least one operation outstanding.

## Operation
- State: `rr_q` (round-robin pointer, $clog2(NrPorts) bits), `lock_q` + `lock_idx_q` (grant hold), ownership FIFO of core indices with count.
- Arbitration: if `lock_q`=0, grant the lowest index ≥`rr_q` with valid; otherwise wrap to the lowest index <`rr_q`. If `lock_q`=1, the grant is `lock_idx_q`.
- `out_req_valid_o` = any granted valid && queue not full. Payload is muxed from the granted core. `in_req_ready_o[g]` = `out_req_ready_i` && queue not full; 0 for all other cores.
- Stall on an offered request (valid && !ready): set `lock_q`, `lock_idx_q`=g. The grant, and therefore the payload, is stable until the handshake.
- Handshake: push g into the FIFO, `rr_q` ← (g+1) mod NrPorts, clear `lock_q`.
- Queue full: no request is offered, even if a pop happens in the same cycle. Lock state is preserved.
- The unit returns responses in issue order. The FIFO head `own` selects the destination core.
- Response path: `out_rsp_valid_o[own]` = `in_rsp_valid_i` && !empty; all other bits 0. `in_rsp_ready_o` = !empty && `out_rsp_ready_i[own]`. Payload passes through unchanged. On a response handshake the FIFO pops.
- Push and pop in the same cycle with queue not full: count unchanged, both take effect.
- Response while the queue is empty is illegal. `in_rsp_ready_o`=0 and an assertion fires.
- `busy_o` = count≠0.

## Timing
- Request path is combinational: 0-cycle latency from the input handshake to the output handshake. Full throughput is one request per cycle while not full.
- Response path is combinational, 0 cycles.
- Reset (`rst_i` high at a clock edge): `rr_q`=0, `lock_q`=0, count=0. While `rst_i` is high, all valids and readies are forced to 0. `busy_o`=0 after the reset edge.
- Reset mid-operation discards all ownership. Responses still in flight afterwards are illegal, and the environment must drain the unit.
- Pointer wrap: grant `NrPorts-1` → `rr_q`=0.

## Structure
- Shared package additions to `snitch_pkg`:
  - an `acc_muldiv_owner_t` typedef is not needed, because the width is local;
  - reuse `acc_addr_e::SHARED_MULDIV` for demux selection upstream.
- Ownership queue: instantiate the common_cells `fifo_v3` (FALL_THROUGH=0, DEPTH=MaxOutstanding, width $clog2(NrPorts)).
- Round-robin selection stays inline. It is a leading-one search over the rotated valid vector.

## Test plan
- Single request: core 2 valid, unit ready → same-cycle handshake, `rr_q`=3, `busy_o`=1. Response data 0x1234 → `out_rsp_valid_o`=4'b0100, data 0x1234, `busy_o`=0.
- All 4 cores valid every cycle, unit always ready → grant order 0,1,2,3,0… Responses return to the matching cores in that order.
- Unit stalls 3 cycles while core 1 is granted; core 0 raises valid meanwhile → grant stays 1 and the payload is stable; core 0 is granted after core 1.
- MaxOutstanding=4, no responses → 5th request blocked (`out_req_valid_o`=0). Response plus new request in the same cycle → request still blocked; issued next cycle.
- Core 3 `out_rsp_ready_i`=0 for 2 cycles → `in_rsp_ready_o`=0, queue head unchanged; pop occurs on the cycle ready rises.
- `rst_i` asserted with 3 outstanding → `busy_o`=0, `rr_q`=0, and the next grant goes to core 0.
